// File: rtl/pwm_servo_pkg.sv
// pwm_servo_pkg: shared defaults, channel-index width and width clamp for pwm_servo_multi
package pwm_servo_pkg;
  localparam int FRAME_DEF = 1_100_000;
  localparam int MIN_PULSE_DEF = 53_500;
  localparam int MAX_PULSE_DEF = 97_500;
  localparam int NEUTRAL_DEF = 75_000;
  localparam int FAILSAFE_FRAMES_DEF = 25;
  typedef struct packed {
    logic ack;
    logic err;
    logic clamped;
  } resp_t;
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // returns {altered, value}
  function automatic logic [64:0] clamp_width(input logic [63:0] w, input logic [63:0] lo, input logic [63:0] hi);
    return (w > hi) ? {1'b1, hi} : (w < lo) ? {1'b1, lo} : {1'b0, w};
  endfunction
endpackage

// File: rtl/pwm_servo_chan.sv
// pwm_servo_chan: one servo output with shadow/active width registers
// optional idle-age failsafe when PWM_SERVO_FAILSAFE_EN is defined
module pwm_servo_chan
  import pwm_servo_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int NEUTRAL = NEUTRAL_DEF,
  parameter int FAILSAFE_FRAMES = FAILSAFE_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic             wrap,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
  output logic             pwm,
  output logic             failsafe
);
  localparam logic [CNT_W-1:0] NEU = CNT_W'(NEUTRAL);
  logic [CNT_W-1:0] shadow, active;
  logic force_neu;
`ifdef PWM_SERVO_FAILSAFE_EN
  localparam int AGE_W = ch_width(FAILSAFE_FRAMES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(FAILSAFE_FRAMES);
  logic [AGE_W-1:0] age;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age <= '0;
    else if (we) age <= '0;
    else if (wrap && age != AGE_MAX) age <= age + AGE_W'(1);
  // a write on the same wrap wins over the forced neutral
  assign force_neu = wrap && !we && age == AGE_MAX - AGE_W'(1);
  assign failsafe = age == AGE_MAX;
`else
  assign force_neu = 1'b0;
  assign failsafe = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow <= NEU;
      active <= NEU;
      pwm <= 1'b0;
    end else begin
      if (we) shadow <= wdata;
      else if (force_neu) shadow <= NEU;
      if (wrap) active <= shadow;
      pwm <= cnt < active;
    end
endmodule

// File: rtl/pwm_servo_multi.sv
// pwm_servo_multi: multi-channel servo PWM, shared frame counter, clamped double-buffered widths
// per-channel failsafe is built only when PWM_SERVO_FAILSAFE_EN is defined
module pwm_servo_multi
  import pwm_servo_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 32,
  parameter int FRAME = FRAME_DEF,
  parameter int MIN_PULSE = MIN_PULSE_DEF,
  parameter int MAX_PULSE = MAX_PULSE_DEF,
  parameter int NEUTRAL = NEUTRAL_DEF,
  parameter int FAILSAFE_FRAMES = FAILSAFE_FRAMES_DEF,
  localparam int CH_W = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [CH_W-1:0]     req_chan,
  input  logic [CNT_W-1:0]    req_width,
  output logic                req_ack,
  output logic                req_err,
  output logic                req_clamped,
  output logic                frame_start,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] failsafe
);
  logic [CNT_W-1:0] cnt, wdata;
  logic [63:0] cval;
  logic cflag, wrap, chan_ok;
  resp_t resp;
  assign wrap = cnt == CNT_W'(FRAME - 1);
  assign frame_start = cnt == '0;
  assign chan_ok = 32'(req_chan) < CHANNELS;
  assign {cflag, cval} = clamp_width(64'(req_width), 64'(MIN_PULSE), 64'(MAX_PULSE));
  assign wdata = CNT_W'(cval);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= wrap ? '0 : cnt + CNT_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) resp <= '0;
    else resp <= {req_valid & chan_ok, req_valid & ~chan_ok, req_valid & chan_ok & cflag};
  assign req_ack = resp.ack;
  assign req_err = resp.err;
  assign req_clamped = resp.clamped;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pwm_servo_chan #(
      .CNT_W(CNT_W),
      .NEUTRAL(NEUTRAL),
      .FAILSAFE_FRAMES(FAILSAFE_FRAMES)
    ) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .cnt(cnt),
      .wrap(wrap),
      .we(req_valid && chan_ok && 32'(req_chan) == g),
      .wdata(wdata),
      .pwm(pwm_out[g]),
      .failsafe(failsafe[g])
    );
  end
endmodule

// File: tb/tb_pwm_servo_multi.sv
// tb_pwm_servo_multi: scoreboard bench for pwm_servo_multi (4-channel and 3-channel builds)
`timescale 1ns/1ps
module tb_pwm_servo_multi;
`ifdef PWM_SERVO_FAILSAFE_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [1:0] a_chan = '0, b_chan = '0;
  logic [31:0] a_width = '0, b_width = '0;
  logic a_ack, a_err, a_clamped, a_fs, b_ack, b_err, b_clamped, b_fs;
  logic [3:0] a_pwm, a_fail;
  logic [2:0] b_pwm, b_fail;
  typedef struct packed {
    logic [3:0][31:0] a;
    logic [2:0][31:0] b;
  } frame_t;
  logic [2:0] qa[$], qb[$];
  frame_t fq[$];
  int tests = 0, fails = 0, pos = 0;

  always #5 clk = ~clk;

  pwm_servo_multi #(.CHANNELS(4), .CNT_W(32), .FRAME(1000), .MIN_PULSE(50), .MAX_PULSE(200),
                    .NEUTRAL(100), .FAILSAFE_FRAMES(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_chan(a_chan), .req_width(a_width),
    .req_ack(a_ack), .req_err(a_err), .req_clamped(a_clamped), .frame_start(a_fs),
    .pwm_out(a_pwm), .failsafe(a_fail));

  pwm_servo_multi #(.CHANNELS(3), .CNT_W(32), .FRAME(1000), .MIN_PULSE(50), .MAX_PULSE(200),
                    .NEUTRAL(100), .FAILSAFE_FRAMES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_chan(b_chan), .req_width(b_width),
    .req_ack(b_ack), .req_err(b_err), .req_clamped(b_clamped), .frame_start(b_fs),
    .pwm_out(b_pwm), .failsafe(b_fail));

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // response monitors: pop one expectation per presented response
  initial forever begin
    logic [2:0] r;
    @(negedge clk);
    if (rst_n && (a_ack || a_err || a_clamped)) begin
      if (qa.size() == 0) chk("a_resp_unexpected", qa.size(), 1);
      else begin
        r = qa.pop_front();
        chk("a_ack", a_ack, r[2]);
        chk("a_err", a_err, r[1]);
        chk("a_clamped", a_clamped, r[0]);
      end
    end
  end

  initial forever begin
    logic [2:0] r;
    @(negedge clk);
    if (rst_n && (b_ack || b_err || b_clamped)) begin
      if (qb.size() == 0) chk("b_resp_unexpected", qb.size(), 1);
      else begin
        r = qb.pop_front();
        chk("b_ack", b_ack, r[2]);
        chk("b_err", b_err, r[1]);
        chk("b_clamped", b_clamped, r[0]);
      end
    end
  end

  // frame monitor: measures period and per-channel high time of each complete frame
  initial begin
    int cyc, fn;
    int ca[4], cb[3];
    bit in_frame;
    frame_t f;
    in_frame = 0;
    fn = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) in_frame = 0;
      else if (a_fs) begin
        if (in_frame) begin
          chk($sformatf("frame%0d_period", fn), cyc, 1000);
          chk($sformatf("frame%0d_b_frame_start", fn), b_fs, 1);
          if (fq.size() == 0) chk("frame_unexpected", fq.size(), 1);
          else begin
            f = fq.pop_front();
            for (int i = 0; i < 4; i++) chk($sformatf("frame%0d_a_width%0d", fn, i), ca[i], f.a[i]);
            for (int i = 0; i < 3; i++) chk($sformatf("frame%0d_b_width%0d", fn, i), cb[i], f.b[i]);
          end
          fn++;
        end
        in_frame = 1;
        cyc = 1;
        for (int i = 0; i < 4; i++) ca[i] = int'(a_pwm[i]);
        for (int i = 0; i < 3; i++) cb[i] = int'(b_pwm[i]);
      end else begin
        cyc++;
        for (int i = 0; i < 4; i++) ca[i] += int'(a_pwm[i]);
        for (int i = 0; i < 3; i++) cb[i] += int'(b_pwm[i]);
      end
    end
  end

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_fs && n < 2000);
    if (!a_fs) chk("frame_start_timeout", a_fs, 1);
  endtask

  // syncs to the next frame start, queues its expected widths; returns with cnt == 1
  task automatic start_frame(input int a0, input int a1, input int a2, input int a3);
    frame_t f;
    wait_fs();
    f.a = {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    f.b = {32'd100, 32'd100, 32'd100};
    fq.push_back(f);
    @(posedge clk);
    #1;
    pos = 1;
  endtask

  // request sampled on the edge where cnt == c; exp = {ack, err, clamped}
  task automatic wr(input bit b, input int c, input int ch, input logic [31:0] w, input logic [2:0] exp);
    repeat (c - pos) @(posedge clk);
    #1;
    if (b) begin
      b_valid = 1'b1;
      b_chan = 2'(ch);
      b_width = w;
      qb.push_back(exp);
    end else begin
      a_valid = 1'b1;
      a_chan = 2'(ch);
      a_width = w;
      qa.push_back(exp);
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    pos = c + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm_a", a_pwm, 0);
    chk("rst_pwm_b", b_pwm, 0);
    chk("rst_failsafe", a_fail, 0);
    chk("rst_resp", {a_ack, a_err, a_clamped}, 0);
    rst_n = 1'b1;
    start_frame(100, 100, 100, 100);
    start_frame(100, 100, 100, 100);
    wr(0, 500, 2, 150, 3'b100);
    start_frame(100, 100, 150, 100);
    chk("failsafe_f2", a_fail, 0);
    wr(0, 300, 1, 0, 3'b101);
    wr(1, 400, 3, 180, 3'b010);
    start_frame(100, 50, 150, 100);
    wr(0, 200, 1, 32'hFFFF_FFFF, 3'b101);
    wr(0, 999, 0, 180, 3'b100);
    start_frame(100, 200, 150, 100);
    start_frame(180, 200, FS ? 100 : 150, 100);
    wr(0, 100, 0, 60, 3'b100);
    wr(0, 101, 0, 70, 3'b100);
    wr(0, 600, 3, 180, 3'b100);
    start_frame(70, 200, FS ? 100 : 150, 180);
    start_frame(70, FS ? 100 : 200, FS ? 100 : 150, 180);
    start_frame(70, FS ? 100 : 200, FS ? 100 : 150, 180);
    start_frame(FS ? 100 : 70, FS ? 100 : 200, FS ? 100 : 150, FS ? 100 : 180);
    chk("failsafe_idle", a_fail, FS ? 4'hF : 4'h0);
    wr(0, 500, 3, 120, 3'b100);
    chk("failsafe_after_write", a_fail, FS ? 4'h7 : 4'h0);
    start_frame(FS ? 100 : 70, FS ? 100 : 200, FS ? 100 : 150, 120);
    wait_fs();
    repeat (50) @(posedge clk);
    #1;
    chk("pwm_high_before_rst", a_pwm, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("pwm_a_async_rst", a_pwm, 0);
    chk("pwm_b_async_rst", b_pwm, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("failsafe_in_rst", a_fail, 0);
    rst_n = 1'b1;
    start_frame(100, 100, 100, 100);
    wait_fs();
    repeat (3) @(posedge clk);
    chk("a_resp_left", qa.size(), 0);
    chk("b_resp_left", qb.size(), 0);
    chk("frames_left", fq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
